uart_result_tx: RTL
===================

# uart_result_tx

UART transmit-side reporter for the finger-operand ALU datapath. It accepts a 2-bit ALU result together with the 2-bit operation code and serializes a fixed 4-byte ASCII frame (8N1, LSB first) back to the host PC. This completes the PC↔FPGA link: the receive path delivers operand B from the PC, and this block returns the computed result. A one-entry pending buffer absorbs a result that arrives while a frame is in flight.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200 baud); legal range ≥ 2.
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- result_valid  in  1  single-cycle pulse; `result` and `op` are valid in this cycle.
- result  in  2  ALU result to report.
- op  in  2  operation code (switch_op) that produced `result`.
- o_Tx_Serial  out  1  UART line; idles high.
- busy  out  1  high while a frame is being sent or the pending entry is full.
- frame_done  out  1  one-cycle pulse after the last stop bit of each frame.
- overrun  out  1  one-cycle pulse when a full pending entry is overwritten.

## Operation
- Frame, in order: 0x52 ('R'), 0x30+op, 0x30+result, 0x0A (LF). Each byte: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held for exactly CLKS_PER_BIT cycles. Bytes within a frame are back-to-back with no idle gap.
- States: IDLE, START, DATA, STOP.
  - IDLE→START: a frame source exists. If pending is full, pending is used and cleared. Otherwise an input pulse is used, if present.
  - START→DATA: after CLKS_PER_BIT cycles.
  - DATA→STOP: after 8 bits; a bit counter counts 0..7.
  - STOP→START: next byte, while the byte index is < 3.
  - STOP→IDLE: after byte index 3.
- `op` and `result` are latched when accepted. Later changes on the inputs do not affect the frame already in progress.
- Pending entry (holds one {op,result} plus a full flag):
  - A result_valid that arrives while state≠IDLE writes to pending.
  - If pending is already full, the entry is overwritten with the newest value and `overrun` pulses in the following cycle.
- In IDLE with pending full and result_valid high in the same cycle: the pending entry launches and the new value goes into pending. No overrun is raised.
- busy = (state≠IDLE) OR pending_full.
- Reset values: o_Tx_Serial=1, busy=0, frame_done=0, overrun=0, state=IDLE, pending cleared, all counters 0.
- Reset asserted mid-frame: on the next edge the line returns high, the partial byte and frame are abandoned, pending is discarded, and no frame_done pulse is issued.

## Timing
- All outputs are registered.
- Acceptance in IDLE at cycle N: o_Tx_Serial goes low (start bit) at N+1, and busy goes high at N+1.
- A frame lasts 40×CLKS_PER_BIT cycles. The last stop-bit cycle is T = N + 40×CLKS_PER_BIT.
- At T+1: state is IDLE, o_Tx_Serial=1, and frame_done=1. busy=0 unless pending is full.
- Pending, or a result_valid at T+1: the start bit begins at T+2. The minimum inter-frame idle gap is 1 cycle.
- overrun is asserted in the cycle after the overwriting result_valid.

## Test plan
- Reset → o_Tx_Serial=1, busy=0, frame_done=0, overrun=0. Hold for 20 cycles with no result_valid → the line stays high.
- CLKS_PER_BIT=4, pulse with op=2'b01, result=2'b11 at cycle N:
  - Decoded bytes are 0x52, 0x31, 0x33, 0x0A.
  - The first byte's line sequence is 0, then 0,1,0,0,1,0,1,0, then 1, each level held 4 cycles starting at N+1.
  - frame_done pulses at N+161.
- While busy, pulse (op=0, result=2) then (op=3, result=1):
  - The second pulse raises overrun for 1 cycle.
  - The following frame sends 0x52, 0x33, 0x31, 0x0A, with its start bit 1 cycle after frame_done.
- result_valid in the same cycle as frame_done (pending empty) → accepted, start bit in the next cycle, and no overrun.
- Reset asserted 50 cycles into a frame → o_Tx_Serial=1 on the next cycle, busy=0, and no frame_done. A pending entry present before reset is never sent.
- Change op/result every cycle after acceptance → the transmitted frame reflects only the values latched at acceptance.

Source files
------------

// File: rtl/uart_result_tx_if.sv
// uart_result_tx_if: result handshake into the UART reporter plus its status/line outputs.
// master drives result_valid/result/op; slave (the reporter) drives o_Tx_Serial/busy/frame_done/overrun.
interface uart_result_tx_if;
    logic       result_valid;
    logic [1:0] result;
    logic [1:0] op;
    logic       o_Tx_Serial;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    modport master (
        output result_valid, result, op,
        input  o_Tx_Serial, busy, frame_done, overrun
    );

    modport slave (
        input  result_valid, result, op,
        output o_Tx_Serial, busy, frame_done, overrun
    );
endinterface

// File: rtl/uart_result_tx.sv
// uart_result_tx: sends the 4-byte ASCII frame "R", '0'+op, '0'+result, LF as 8N1 UART.
// Ports: clk, reset (sync, active-high), bus (slave): result_valid/result/op in; line/busy/frame_done/overrun out.
module uart_result_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      clk,
    input  logic      reset,
    uart_result_tx_if.slave bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [1:0]  byte_idx, byte_idx_n;
    logic [1:0]  lat_op, lat_op_n;
    logic [1:0]  lat_res, lat_res_n;
    logic [1:0]  pend_op, pend_op_n;
    logic [1:0]  pend_res, pend_res_n;
    logic        pend_full, pend_full_n;
    logic        tx, tx_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic        ovr_q, ovr_n;
    logic [7:0]  cur_byte;

    always_comb begin
        unique case (byte_idx)
            2'd0:    cur_byte = 8'h52;
            2'd1:    cur_byte = {6'b001100, lat_op};
            2'd2:    cur_byte = {6'b001100, lat_res};
            default: cur_byte = 8'h0A;
        endcase
    end

    // Line level is computed for the next state so the output stays registered.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        byte_idx_n  = byte_idx;
        lat_op_n    = lat_op;
        lat_res_n   = lat_res;
        pend_op_n   = pend_op;
        pend_res_n  = pend_res;
        pend_full_n = pend_full;
        tx_n        = tx;
        done_n      = 1'b0;
        ovr_n       = 1'b0;

        case (state)
            IDLE: begin
                if (pend_full || bus.result_valid) begin
                    state_n    = START;
                    cnt_n      = '0;
                    bit_idx_n  = '0;
                    byte_idx_n = '0;
                    tx_n       = 1'b0;
                end
                if (pend_full) begin
                    lat_op_n    = pend_op;
                    lat_res_n   = pend_res;
                    pend_full_n = 1'b0;
                    // Pending launches; a simultaneous pulse refills it without overrun.
                    if (bus.result_valid) begin
                        pend_op_n   = bus.op;
                        pend_res_n  = bus.result;
                        pend_full_n = 1'b1;
                    end
                end else if (bus.result_valid) begin
                    lat_op_n  = bus.op;
                    lat_res_n = bus.result;
                end
            end
            START: begin
                if (cnt == LAST) begin
                    state_n   = DATA;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    tx_n      = cur_byte[0];
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = cur_byte[bit_idx + 3'd1];
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (byte_idx == 2'd3) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        tx_n    = 1'b1;
                    end else begin
                        byte_idx_n = byte_idx + 2'd1;
                        state_n    = START;
                        tx_n       = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        endcase

        if (state != IDLE && bus.result_valid) begin
            pend_op_n   = bus.op;
            pend_res_n  = bus.result;
            pend_full_n = 1'b1;
            ovr_n       = pend_full;
        end

        busy_n = (state_n != IDLE) || pend_full_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            lat_op    <= '0;
            lat_res   <= '0;
            pend_op   <= '0;
            pend_res  <= '0;
            pend_full <= 1'b0;
            tx        <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            byte_idx  <= byte_idx_n;
            lat_op    <= lat_op_n;
            lat_res   <= lat_res_n;
            pend_op   <= pend_op_n;
            pend_res  <= pend_res_n;
            pend_full <= pend_full_n;
            tx        <= tx_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            ovr_q     <= ovr_n;
        end
    end

    assign bus.o_Tx_Serial = tx;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = done_q;
    assign bus.overrun     = ovr_q;

endmodule
